// File: rtl/lag_pattern_gen.sv
// lag_pattern_gen: video timing and flash-pattern generator for the latency tester.
// Produces hsync/vsync/de and RGB, flashes NUM_FIELDS rectangles on a frame-counted
// DARK/FLASH schedule, and emits starttrigger aligned with the first flashed pixel.
// Optional feature macro: FLASH_COLOR_EN adds a flash_color input sampled with the
// config; without it, fields are drawn white.
//
// state | meaning
// IDLE  | no timing loaded, outputs quiet, any valid config accepted at once
// DARK  | running, fields not drawn; leaves at a phase boundary
// FLASH | running, fields drawn; returns to DARK after one phase
module lag_pattern_gen #(
  parameter int CW           = 12,
  parameter int NUM_FIELDS   = 3,
  parameter int FLASH_FRAMES = 6,
  parameter int OUT_DELAY    = 2,
  parameter int DW           = 8
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic [8*CW+1:0]            cfg_timing,
  input  logic [NUM_FIELDS*4*CW-1:0] cfg_fields,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  output logic                       cfg_error,
  input  logic                       single_shot,
  input  logic                       arm,
`ifdef FLASH_COLOR_EN
  input  logic [3*DW-1:0]            flash_color,
`endif
  output logic [DW-1:0]              red,
  output logic [DW-1:0]              green,
  output logic [DW-1:0]              blue,
  output logic                       de,
  output logic                       hsync,
  output logic                       vsync,
  output logic                       starttrigger,
  output logic                       flashing
);

  localparam int FCW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam int VW  = 4 + 3*DW;

  typedef enum logic [1:0] {IDLE, DARK, FLASH} state_t;

  state_t                       state;
  logic [CW-1:0]                x, y;
  logic [FCW-1:0]               frame_cnt;
  logic                         arm_q;
  logic [CW-1:0]                h_sync, h_bp, h_active, h_total;
  logic [CW-1:0]                v_sync, v_bp, v_active, v_total;
  logic                         h_pol, v_pol;
  logic [NUM_FIELDS*4*CW-1:0]   fields_q;
  logic [3*DW-1:0]              color;
`ifdef FLASH_COLOR_EN
  logic [3*DW-1:0]              color_q;
  assign color = color_q;
`else
  assign color = '1;
`endif

  // incoming config fields and their consistency check
  logic [CW-1:0] n_h_sync, n_h_bp, n_h_active, n_h_total;
  logic [CW-1:0] n_v_sync, n_v_bp, n_v_active, n_v_total;
  logic [CW:0]   n_h_sum, n_v_sum;
  logic          cfg_ok, running, x_wrap, y_wrap, cfg_window;

  assign n_h_sync   = cfg_timing[8*CW+1 -: CW];
  assign n_h_bp     = cfg_timing[7*CW+1 -: CW];
  assign n_h_active = cfg_timing[6*CW+1 -: CW];
  assign n_h_total  = cfg_timing[5*CW+1 -: CW];
  assign n_v_sync   = cfg_timing[4*CW+1 -: CW];
  assign n_v_bp     = cfg_timing[3*CW+1 -: CW];
  assign n_v_active = cfg_timing[2*CW+1 -: CW];
  assign n_v_total  = cfg_timing[CW+1 -: CW];

  assign n_h_sum = {1'b0, n_h_sync} + {1'b0, n_h_bp} + {1'b0, n_h_active};
  assign n_v_sum = {1'b0, n_v_sync} + {1'b0, n_v_bp} + {1'b0, n_v_active};
  assign cfg_ok  = (n_h_sum <= {1'b0, n_h_total}) && (n_v_sum <= {1'b0, n_v_total}) &&
                   (n_h_total >= CW'(2)) && (n_v_total >= CW'(1));

  assign running    = (state != IDLE);
  assign x_wrap     = (x == h_total - CW'(1));
  assign y_wrap     = (y == v_total - CW'(1));
  // a running block only swaps timing on the last pixel so frames never tear
  assign cfg_window = (state == IDLE) || (x_wrap && y_wrap);
  assign cfg_ready  = cfg_valid && cfg_ok && cfg_window;
  assign cfg_error  = cfg_valid && !cfg_ok && cfg_window;
  assign flashing   = (state == FLASH);

  // config load, pixel/line/frame counters and the DARK/FLASH schedule
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= IDLE;
      x         <= '0;
      y         <= '0;
      frame_cnt <= '0;
      arm_q     <= 1'b0;
      h_sync    <= '0;
      h_bp      <= '0;
      h_active  <= '0;
      h_total   <= '0;
      v_sync    <= '0;
      v_bp      <= '0;
      v_active  <= '0;
      v_total   <= '0;
      h_pol     <= 1'b0;
      v_pol     <= 1'b0;
      fields_q  <= '0;
`ifdef FLASH_COLOR_EN
      color_q   <= '0;
`endif
    end else if (cfg_ready) begin
      state     <= DARK;
      x         <= '0;
      y         <= '0;
      frame_cnt <= '0;
      arm_q     <= 1'b0;
      h_sync    <= n_h_sync;
      h_bp      <= n_h_bp;
      h_active  <= n_h_active;
      h_total   <= n_h_total;
      v_sync    <= n_v_sync;
      v_bp      <= n_v_bp;
      v_active  <= n_v_active;
      v_total   <= n_v_total;
      h_pol     <= cfg_timing[1];
      v_pol     <= cfg_timing[0];
      fields_q  <= cfg_fields;
`ifdef FLASH_COLOR_EN
      color_q   <= flash_color;
`endif
    end else if (running) begin
      if (arm && state == DARK) arm_q <= 1'b1;
      if (x_wrap) begin
        x <= '0;
        if (y_wrap) begin
          y <= '0;
          if (frame_cnt == FCW'(FLASH_FRAMES - 1)) begin
            frame_cnt <= '0;
            if (state == FLASH) begin
              state <= DARK;
            end else if (!single_shot || arm_q || arm) begin
              // a same-cycle arm counts for this boundary; the latch is consumed here
              state <= FLASH;
              arm_q <= 1'b0;
            end
          end else begin
            frame_cnt <= frame_cnt + FCW'(1);
          end
        end else begin
          y <= y + CW'(1);
        end
      end else begin
        x <= x + CW'(1);
      end
    end
  end

  // pixel decode of the current counter state
  logic [CW:0]          h_start, h_end, v_start, v_end, x_ext, y_ext;
  logic [CW-1:0]        vx, vy;
  logic [4*CW-1:0]      fld;
  logic                 hit, d_de, d_hs, d_vs, d_trig;
  logic [3*DW-1:0]      d_rgb;

  assign h_start = {1'b0, h_sync} + {1'b0, h_bp};
  assign h_end   = h_start + {1'b0, h_active};
  assign v_start = {1'b0, v_sync} + {1'b0, v_bp};
  assign v_end   = v_start + {1'b0, v_active};
  assign x_ext   = {1'b0, x};
  assign y_ext   = {1'b0, y};
  assign vx      = x - h_start[CW-1:0];
  assign vy      = y - v_start[CW-1:0];

  // any-field hit test in visible coordinates, start inclusive, end exclusive
  always_comb begin
    hit = 1'b0;
    fld = '0;
    for (int i = 0; i < NUM_FIELDS; i++) begin
      fld = fields_q[i*4*CW +: 4*CW];
      if (vx >= fld[4*CW-1 -: CW] && vx < fld[3*CW-1 -: CW] &&
          vy >= fld[2*CW-1 -: CW] && vy < fld[CW-1:0])
        hit = 1'b1;
    end
  end

  assign d_de   = running && (x_ext >= h_start) && (x_ext < h_end) &&
                  (y_ext >= v_start) && (y_ext < v_end);
  assign d_hs   = running && ((x < h_sync) ? h_pol : !h_pol);
  assign d_vs   = running && ((y < v_sync) ? v_pol : !v_pol);
  // first active pixel of the first frame of a FLASH phase
  assign d_trig = d_de && (state == FLASH) && (frame_cnt == '0) &&
                  (x_ext == h_start) && (y_ext == v_start);
  assign d_rgb  = (d_de && state == FLASH && hit) ? color : '0;

  logic [VW-1:0] pipe [0:OUT_DELAY];

  // one decode register plus OUT_DELAY alignment stages, flushed by reset
  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int i = 0; i <= OUT_DELAY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= {d_de, d_hs, d_vs, d_trig, d_rgb};
      for (int i = 1; i <= OUT_DELAY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign {de, hsync, vsync, starttrigger, red, green, blue} = pipe[OUT_DELAY];

endmodule

// File: tb/tb_lag_pattern_gen.sv
// Directed bench for lag_pattern_gen with default parameters (OUT_DELAY=2, FLASH_FRAMES=6).
// Small timing: h 2/2/8/16, v 1/1/4/8 -> 128 cycles per frame. cyc 0 is the first cycle
// after the accepting edge; the pixel shown at the pins in cycle c is counter state c-3.
module tb_lag_pattern_gen;

  localparam int CW = 12;
  localparam int NF = 3;
  localparam int DW = 8;

  localparam logic [8*CW+1:0] T_SMALL = {12'd2, 12'd2, 12'd8, 12'd16, 12'd1, 12'd1, 12'd4, 12'd8, 1'b1, 1'b1};
  localparam logic [8*CW+1:0] T_BAD   = {12'd1, 12'd1, 12'd16, 12'd16, 12'd1, 12'd1, 12'd4, 12'd8, 1'b1, 1'b1};
  localparam logic [8*CW+1:0] T_NEW   = {12'd1, 12'd1, 12'd8, 12'd12, 12'd1, 12'd1, 12'd4, 12'd8, 1'b0, 1'b0};
  localparam logic [8*CW+1:0] T_TINY  = {12'd0, 12'd0, 12'd1, 12'd1, 12'd0, 12'd0, 12'd1, 12'd1, 1'b1, 1'b1};
  localparam logic [8*CW+1:0] T_VGA   = {12'd96, 12'd48, 12'd640, 12'd800, 12'd2, 12'd33, 12'd480, 12'd525, 1'b0, 1'b0};
  localparam logic [NF*4*CW-1:0] F_SMALL = {{12'd7, 12'd8, 12'd3, 12'd4},
                                            {12'd3, 12'd3, 12'd0, 12'd4},
                                            {12'd2, 12'd5, 12'd1, 12'd3}};
`ifdef FLASH_COLOR_EN
  localparam logic [3*DW-1:0] FLASH_RGB = 24'h123456;
`else
  localparam logic [3*DW-1:0] FLASH_RGB = 24'hFFFFFF;
`endif

  logic clock = 1'b0;
  logic resetn;
  logic [8*CW+1:0] cfg_timing;
  logic [NF*4*CW-1:0] cfg_fields;
  logic cfg_valid, cfg_ready, cfg_error, single_shot, arm;
  logic [DW-1:0] red, green, blue;
  logic de, hsync, vsync, starttrigger, flashing;
`ifdef FLASH_COLOR_EN
  logic [3*DW-1:0] flash_color = 24'h123456;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int trig_seen = 0;
  int de_seen = 0;

  always #5 clock = ~clock;

  lag_pattern_gen dut (
    .clock(clock), .resetn(resetn), .cfg_timing(cfg_timing), .cfg_fields(cfg_fields),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_error(cfg_error),
    .single_shot(single_shot), .arm(arm),
`ifdef FLASH_COLOR_EN
    .flash_color(flash_color),
`endif
    .red(red), .green(green), .blue(blue), .de(de), .hsync(hsync), .vsync(vsync),
    .starttrigger(starttrigger), .flashing(flashing));

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    if (starttrigger === 1'b1) trig_seen++;
    if (de === 1'b1) de_seen++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    cfg_valid = 1'b0;
    arm = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic accept(input logic [8*CW+1:0] t);
    cfg_timing = t;
    cfg_fields = F_SMALL;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    cyc = 0;
    trig_seen = 0;
    de_seen = 0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    cfg_valid = 1'b0;
    arm = 1'b0;
    single_shot = 1'b0;
    cfg_timing = '0;
    cfg_fields = '0;
    tick();
    tick();
    checks++;
    if ({de, hsync, vsync, starttrigger, flashing, cfg_ready, cfg_error, red, green, blue} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0",
               {de, hsync, vsync, starttrigger, flashing, cfg_ready, cfg_error, red, green, blue});
    end
    resetn = 1'b1;
    tick();
    cfg_timing = T_SMALL;
    cfg_valid = 1'b1;
    #1;
    checks++;
    if ({cfg_ready, cfg_error} !== 2'b10) begin
      errors++;
      $display("FAIL idle_ready got %b want 10", {cfg_ready, cfg_error});
    end
    cfg_valid = 1'b0;
    #1;
    checks++;
    if (cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready_drop got %b want 0", cfg_ready);
    end
  endtask

  task automatic test_idle_reject();
    do_reset();
    cfg_timing = T_TINY;
    cfg_valid = 1'b1;
    #1;
    checks++;
    if ({cfg_ready, cfg_error} !== 2'b01) begin
      errors++;
      $display("FAIL idle_reject got %b want 01", {cfg_ready, cfg_error});
    end
    tick();
    cfg_valid = 1'b0;
    de_seen = 0;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (de_seen != 0 || flashing !== 1'b0 || hsync !== 1'b0) begin
      errors++;
      $display("FAIL idle_stays de_seen=%0d flashing=%b hsync=%b want 0 0 0", de_seen, flashing, hsync);
    end
  endtask

  task automatic test_timing();
    do_reset();
    single_shot = 1'b0;
    accept(T_SMALL);
    run_to(3);
    checks++;
    if ({hsync, vsync, de} !== 3'b110) begin
      errors++;
      $display("FAIL sync_start got %b want 110", {hsync, vsync, de});
    end
    run_to(5);
    checks++;
    if (hsync !== 1'b0) begin errors++; $display("FAIL hsync_end got %b want 0", hsync); end
    run_to(19);
    checks++;
    if ({hsync, vsync} !== 2'b10) begin errors++; $display("FAIL vsync_end got %b want 10", {hsync, vsync}); end
    run_to(38);
    checks++;
    if (de !== 1'b0) begin errors++; $display("FAIL de_before got %b want 0", de); end
    run_to(39);
    checks++;
    if (de !== 1'b1) begin errors++; $display("FAIL de_first got %b want 1", de); end
    run_to(57);
    checks++;
    if ({de, red, green, blue} !== {1'b1, 24'h0}) begin
      errors++;
      $display("FAIL dark_field got %h want 1000000", {de, red, green, blue});
    end
    run_to(94);
    checks++;
    if (de !== 1'b1) begin errors++; $display("FAIL de_last got %b want 1", de); end
    run_to(95);
    checks++;
    if (de !== 1'b0) begin errors++; $display("FAIL de_after got %b want 0", de); end
  endtask

  task automatic test_fields();
    run_to(767);
    checks++;
    if (flashing !== 1'b0) begin errors++; $display("FAIL flash_pre got %b want 0", flashing); end
    run_to(768);
    checks++;
    if (flashing !== 1'b1) begin errors++; $display("FAIL flash_on got %b want 1", flashing); end
    run_to(806);
    checks++;
    if (starttrigger !== 1'b0) begin errors++; $display("FAIL trig_early got %b want 0", starttrigger); end
    run_to(807);
    checks++;
    if ({starttrigger, de, red, green, blue} !== {2'b11, 24'h0}) begin
      errors++;
      $display("FAIL trig_first got %h want 3000000", {starttrigger, de, red, green, blue});
    end
    run_to(808);
    checks++;
    if (starttrigger !== 1'b0) begin errors++; $display("FAIL trig_once got %b want 0", starttrigger); end
    run_to(810);
    checks++;
    if ({de, red, green, blue} !== {1'b1, 24'h0}) begin
      errors++;
      $display("FAIL empty_field got %h want 1000000", {de, red, green, blue});
    end
    run_to(825);
    checks++;
    if ({red, green, blue} !== FLASH_RGB) begin
      errors++;
      $display("FAIL field_start got %h want %h", {red, green, blue}, FLASH_RGB);
    end
    run_to(828);
    checks++;
    if ({red, green, blue} !== 24'h0) begin errors++; $display("FAIL field_xend got %h want 0", {red, green, blue}); end
    run_to(843);
    checks++;
    if ({red, green, blue} !== FLASH_RGB) begin
      errors++;
      $display("FAIL field_inner got %h want %h", {red, green, blue}, FLASH_RGB);
    end
    run_to(857);
    checks++;
    if ({red, green, blue} !== 24'h0) begin errors++; $display("FAIL field_yend got %h want 0", {red, green, blue}); end
    run_to(862);
    checks++;
    if ({red, green, blue} !== FLASH_RGB) begin
      errors++;
      $display("FAIL field2 got %h want %h", {red, green, blue}, FLASH_RGB);
    end
  endtask

  task automatic test_schedule();
    run_to(1535);
    checks++;
    if (flashing !== 1'b1) begin errors++; $display("FAIL flash_hold got %b want 1", flashing); end
    run_to(1536);
    checks++;
    if (flashing !== 1'b0) begin errors++; $display("FAIL flash_off got %b want 0", flashing); end
    run_to(2304);
    checks++;
    if (flashing !== 1'b1) begin errors++; $display("FAIL flash_again got %b want 1", flashing); end
    run_to(2343);
    checks++;
    if (starttrigger !== 1'b1) begin errors++; $display("FAIL trig_second got %b want 1", starttrigger); end
    checks++;
    if (trig_seen != 2) begin errors++; $display("FAIL trig_count got %0d want 2", trig_seen); end
  endtask

  task automatic test_single_shot();
    do_reset();
    single_shot = 1'b1;
    accept(T_SMALL);
    run_to(434);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    run_to(767);
    checks++;
    if (flashing !== 1'b0) begin errors++; $display("FAIL ss_pre got %b want 0", flashing); end
    run_to(768);
    checks++;
    if (flashing !== 1'b1) begin errors++; $display("FAIL ss_on got %b want 1", flashing); end
    run_to(807);
    checks++;
    if (starttrigger !== 1'b1) begin errors++; $display("FAIL ss_trig got %b want 1", starttrigger); end
    run_to(900);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    run_to(1536);
    checks++;
    if (flashing !== 1'b0) begin errors++; $display("FAIL ss_off got %b want 0", flashing); end
    run_to(2304);
    checks++;
    if (flashing !== 1'b0) begin errors++; $display("FAIL ss_no_second got %b want 0", flashing); end
    checks++;
    if (trig_seen != 1) begin errors++; $display("FAIL ss_trig_count got %0d want 1", trig_seen); end
    run_to(3071);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    checks++;
    if (flashing !== 1'b1) begin errors++; $display("FAIL ss_arm_boundary got %b want 1", flashing); end
  endtask

  task automatic test_cfg_update();
    do_reset();
    single_shot = 1'b0;
    accept(T_SMALL);
    run_to(100);
    cfg_timing = T_BAD;
    cfg_valid = 1'b1;
    run_to(126);
    checks++;
    if ({cfg_ready, cfg_error} !== 2'b00) begin
      errors++;
      $display("FAIL bad_wait got %b want 00", {cfg_ready, cfg_error});
    end
    run_to(127);
    checks++;
    if ({cfg_ready, cfg_error} !== 2'b01) begin
      errors++;
      $display("FAIL bad_error got %b want 01", {cfg_ready, cfg_error});
    end
    tick();
    cfg_valid = 1'b0;
    run_to(165);
    checks++;
    if (de !== 1'b0) begin errors++; $display("FAIL bad_kept_a got %b want 0", de); end
    run_to(167);
    checks++;
    if (de !== 1'b1) begin errors++; $display("FAIL bad_kept_b got %b want 1", de); end
    run_to(200);
    cfg_timing = T_NEW;
    cfg_valid = 1'b1;
    run_to(254);
    checks++;
    if (cfg_ready !== 1'b0) begin errors++; $display("FAIL new_early got %b want 0", cfg_ready); end
    run_to(255);
    checks++;
    if ({cfg_ready, cfg_error} !== 2'b10) begin
      errors++;
      $display("FAIL new_ready got %b want 10", {cfg_ready, cfg_error});
    end
    tick();
    cfg_valid = 1'b0;
    run_to(259);
    checks++;
    if ({hsync, vsync} !== 2'b00) begin errors++; $display("FAIL new_pol got %b want 00", {hsync, vsync}); end
    run_to(260);
    checks++;
    if (hsync !== 1'b1) begin errors++; $display("FAIL new_hsync got %b want 1", hsync); end
    run_to(284);
    checks++;
    if (de !== 1'b0) begin errors++; $display("FAIL new_de_before got %b want 0", de); end
    run_to(285);
    checks++;
    if (de !== 1'b1) begin errors++; $display("FAIL new_de_first got %b want 1", de); end
    run_to(831);
    checks++;
    if (flashing !== 1'b0) begin errors++; $display("FAIL new_frame_reset got %b want 0", flashing); end
    run_to(832);
    checks++;
    if (flashing !== 1'b1) begin errors++; $display("FAIL new_flash got %b want 1", flashing); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    single_shot = 1'b0;
    accept(T_SMALL);
    run_to(824);
    checks++;
    if ({de, flashing} !== 2'b11) begin errors++; $display("FAIL mid_running got %b want 11", {de, flashing}); end
    resetn = 1'b0;
    tick();
    checks++;
    if ({de, hsync, vsync, starttrigger, flashing, red, green, blue} !== '0) begin
      errors++;
      $display("FAIL mid_reset got %h want 0", {de, hsync, vsync, starttrigger, flashing, red, green, blue});
    end
    resetn = 1'b1;
    tick();
    cfg_timing = T_SMALL;
    cfg_valid = 1'b1;
    #1;
    checks++;
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b want 1", cfg_ready); end
    cfg_valid = 1'b0;
    trig_seen = 0;
    de_seen = 0;
    for (int i = 0; i < 300; i++) tick();
    checks++;
    if (trig_seen != 0 || de_seen != 0) begin
      errors++;
      $display("FAIL mid_quiet trig=%0d de=%0d want 0 0", trig_seen, de_seen);
    end
  endtask

  task automatic test_vga();
    do_reset();
    single_shot = 1'b0;
    accept(T_VGA);
    run_to(3);
    checks++;
    if ({hsync, vsync} !== 2'b00) begin errors++; $display("FAIL vga_sync got %b want 00", {hsync, vsync}); end
    run_to(99);
    checks++;
    if (hsync !== 1'b1) begin errors++; $display("FAIL vga_hsync_end got %b want 1", hsync); end
    run_to(28146);
    checks++;
    if (de !== 1'b0) begin errors++; $display("FAIL vga_de_before got %b want 0", de); end
    run_to(28147);
    checks++;
    if (de !== 1'b1) begin errors++; $display("FAIL vga_de_first got %b want 1", de); end
  endtask

  initial begin
    test_reset();
    test_idle_reject();
    test_timing();
    test_fields();
    test_schedule();
    test_single_shot();
    test_cfg_update();
    test_reset_mid();
    test_vga();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
